echo_meas: RTL and testbench
============================

Name: echo_meas

Overview:
- Measures the HC-SR04 echo pulse that follows each trig pulse, and reports the pulse width in prescaled ticks (default 1 us at 50 MHz).
- Sits directly downstream of the trig pulse generator. Control drives arm on the same edge that starts trig; echo_meas then waits for the echo rising edge, times the high phase, and hands a result word to the distance/report logic.

Parameters:
- CNT_LEN, 16, width of the width result and of the internal width counter.
- TICK_DIV, 50, clk cycles per measurement tick; must be >= 2.
- WAIT_MAX, 30000, ticks to wait in ARMED for the echo rising edge before declaring timeout; must be < 2^CNT_LEN.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- arm  input  1  start request; acted on at its rising edge, and only in IDLE.
- echo  input  1  raw echo pin, asynchronous to clk.
- ready  output  1  high only in IDLE.
- valid  output  1  one-cycle strobe; width and timeout_err are meaningful in this cycle and hold until the next valid.
- width  output  CNT_LEN  measured high time in ticks (in cm with ECHO_CM_EN).
- timeout_err  output  1  no echo rising edge within WAIT_MAX ticks, or width saturated.

Behaviour:
- Reset (async, immediate): state=IDLE, all counters/prescaler/sync flops=0. Outputs: ready=1, valid=0, width=0, timeout_err=0.
- Echo sync: 2-flop synchroniser, then a 3rd flop for edge detect. rise = s & !s_d; fall = !s & s_d.
- arm edge: registered arm_d; start = arm & !arm_d.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 when it equals TICK_DIV-1. Cleared to 0 on start and on entering MEASURE.
- States: IDLE, ARMED, MEASURE, DONE (plus DIVIDE, see Optional Feature).
- IDLE: on start -> ARMED; wait_cnt=0, width_cnt=0. arm rising in any other state is ignored, not queued.
- ARMED:
  - rise -> MEASURE.
  - else on tick, wait_cnt+1; wait_cnt reaching WAIT_MAX -> DONE with err=1, result=0.
  - rise and final tick in the same cycle: rise wins.
  - echo already high at arm: no rise occurs, so the measurement times out.
- MEASURE:
  - On tick, width_cnt+1, saturating at 2^CNT_LEN-1.
  - fall -> DONE with result = width_cnt + tick (saturated), err=0.
  - If width_cnt reaches 2^CNT_LEN-1 -> DONE with err=1, result=all-ones, without waiting for fall.
- DONE: one cycle. Registers width/timeout_err from the result, drives valid=1 for that cycle, then -> IDLE.
- Latency: echo pin falling, first sampled low at clk edge k, gives valid high in the cycle after edge k+3.
- Outputs width and timeout_err change only at DONE.
- Back-to-back measurements: the next start is accepted from the cycle after valid.

Optional Feature:
- Macro: ECHO_CM_EN.
- Defined:
  - Non-error results enter a DIVIDE state after MEASURE instead of going straight to DONE.
  - DIVIDE divides by 58 with restoring repeated subtraction, one subtraction per clk.
  - quotient (cm) becomes width; remainder is discarded.
  - valid is delayed by floor(result/58)+1 cycles. ready stays low throughout.
  - Timeout/saturation results bypass DIVIDE, with width=0 / all-ones as before.
- Undefined: no DIVIDE state, no divider logic; width is in ticks.

Test Plan:
- rst asserted mid-MEASURE (no clk edge needed) -> ready=1, valid=0, width=0, timeout_err=0 immediately. After release with echo high, no valid appears until a new arm.
- TICK_DIV=4, CNT_LEN=8: arm pulse, echo high 8 clk later for 40 clk -> exactly one valid, width=10, timeout_err=0, valid 4 cycles after the falling-edge sample.
- TICK_DIV=4, WAIT_MAX=10: arm, echo held low -> valid after 40 clk (+/-2), timeout_err=1, width=0, ready returns next cycle.
- TICK_DIV=4, CNT_LEN=8: echo held high 1100 clk -> valid with width=255, timeout_err=1 before echo falls. A later fall produces no extra valid.
- arm held high for 200 clk, plus a second arm pulse during MEASURE -> only one measurement. A new arm rising edge after valid starts a second one correctly.
- ECHO_CM_EN, TICK_DIV=50: echo high 29000 clk (580 ticks) -> width=10, valid 11 cycles later than in the non-CM build; 57 ticks -> width=0.

Source files
------------

// File: rtl/echo_meas_if.sv
// echo_meas_if: groups the arm/echo request side and the result side of echo_meas.
// The master drives arm and echo and receives the result; the slave is the meter itself.
interface echo_meas_if #(
  parameter int CNT_LEN = 16
);
  logic               arm;
  logic               echo;
  logic               ready;
  logic               valid;
  logic [CNT_LEN-1:0] width;
  logic               timeout_err;

  modport master (
    output arm,
    output echo,
    input  ready,
    input  valid,
    input  width,
    input  timeout_err
  );

  modport slave (
    input  arm,
    input  echo,
    output ready,
    output valid,
    output width,
    output timeout_err
  );
endinterface

// File: rtl/echo_meas.sv
// echo_meas: times the HC-SR04 echo high phase after each arm and reports it in prescaled ticks.
// Define ECHO_CM_EN to convert non-error results to centimetres (divide by 58) before reporting.
module echo_meas #(
  parameter int CNT_LEN  = 16,
  parameter int TICK_DIV = 50,
  parameter int WAIT_MAX = 30000
) (
  input  logic       clk,
  input  logic       rst,
  echo_meas_if.slave bus
);

  localparam int                 PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]      TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_LEN-1:0] CNT_MAX   = {CNT_LEN{1'b1}};
  localparam logic [CNT_LEN-1:0] WAIT_LAST = CNT_LEN'(WAIT_MAX - 1);

`ifdef ECHO_CM_EN
  localparam logic [CNT_LEN-1:0] CM_DIV = CNT_LEN'(58);
  typedef enum logic [2:0] {IDLE, ARMED, MEASURE, DIVIDE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
`endif

  state_t state, state_n;

  logic               echo_s1, echo_s2, echo_s3, arm_d;
  logic               rise, fall, start, tick;
  logic [PW-1:0]      presc;
  logic [CNT_LEN-1:0] wait_cnt, width_cnt, meas_sum;
  logic               res_load, res_err_n, res_err;
  logic [CNT_LEN-1:0] res_width_n, res_width;
  logic               valid_q, err_q;
  logic [CNT_LEN-1:0] width_q;
`ifdef ECHO_CM_EN
  logic               div_load;
  logic [CNT_LEN-1:0] div_rem, div_quo;
`endif

  // Echo is asynchronous: two synchroniser flops, the third only feeds edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_s1 <= 1'b0;
      echo_s2 <= 1'b0;
      echo_s3 <= 1'b0;
      arm_d   <= 1'b0;
    end else begin
      echo_s1 <= bus.echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      arm_d   <= bus.arm;
    end
  end

  assign rise  = echo_s2 & ~echo_s3;
  assign fall  = ~echo_s2 & echo_s3;
  assign start = bus.arm & ~arm_d;
  assign tick  = (presc == TICK_LAST);

  // Width including the tick of the current cycle, clamped at all-ones.
  always_comb begin
    meas_sum = width_cnt;
    if (tick && (width_cnt != CNT_MAX)) meas_sum = width_cnt + CNT_LEN'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    res_load    = 1'b0;
    res_width_n = '0;
    res_err_n   = 1'b0;
`ifdef ECHO_CM_EN
    div_load    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) state_n = ARMED;
      end
      ARMED: begin
        if (rise) begin
          state_n = MEASURE;
        end else if (tick && (wait_cnt == WAIT_LAST)) begin
          state_n   = DONE;
          res_load  = 1'b1;
          res_err_n = 1'b1;
        end
      end
      MEASURE: begin
        if (fall || (meas_sum == CNT_MAX)) begin
`ifdef ECHO_CM_EN
          if (meas_sum == CNT_MAX) begin
            state_n     = DONE;
            res_load    = 1'b1;
            res_width_n = CNT_MAX;
            res_err_n   = 1'b1;
          end else begin
            state_n  = DIVIDE;
            div_load = 1'b1;
          end
`else
          state_n     = DONE;
          res_load    = 1'b1;
          res_width_n = meas_sum;
          res_err_n   = (meas_sum == CNT_MAX);
`endif
        end
      end
`ifdef ECHO_CM_EN
      DIVIDE: begin
        if (div_rem < CM_DIV) begin
          state_n     = DONE;
          res_load    = 1'b1;
          res_width_n = div_quo;
        end
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Prescaler restarts with each new arm and again at the echo rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      wait_cnt  <= '0;
      width_cnt <= '0;
    end else begin
      if (((state == IDLE) && start) || ((state == ARMED) && rise) || tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if ((state == IDLE) && start) begin
        wait_cnt  <= '0;
        width_cnt <= '0;
      end else begin
        if ((state == ARMED) && tick && !rise) wait_cnt <= wait_cnt + CNT_LEN'(1);
        if (state == MEASURE) width_cnt <= meas_sum;
      end
    end
  end

`ifdef ECHO_CM_EN
  // Restoring division by repeated subtraction, one step per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_rem <= '0;
      div_quo <= '0;
    end else if (div_load) begin
      div_rem <= meas_sum;
      div_quo <= '0;
    end else if ((state == DIVIDE) && (div_rem >= CM_DIV)) begin
      div_rem <= div_rem - CM_DIV;
      div_quo <= div_quo + CNT_LEN'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_width <= '0;
      res_err   <= 1'b0;
      width_q   <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (res_load) begin
        res_width <= res_width_n;
        res_err   <= res_err_n;
      end
      if (state == DONE) begin
        width_q <= res_width;
        err_q   <= res_err;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.ready       = (state == IDLE);
  assign bus.valid       = valid_q;
  assign bus.width       = width_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_echo_meas.sv
// tb_echo_meas: table-driven and randomized checks of echo_meas against a cycle-level model
// derived from the tick/timeout/saturation rules (TICK_DIV=4, CNT_LEN=8, WAIT_MAX=10).
`timescale 1ns/1ps
module tb_echo_meas;

  localparam int CNT_LEN  = 8;
  localparam int TICK_DIV = 4;
  localparam int WAIT_MAX = 10;
  localparam int MAXV     = (1 << CNT_LEN) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  echo_meas_if #(.CNT_LEN(CNT_LEN)) bus ();

  echo_meas #(
    .CNT_LEN (CNT_LEN),
    .TICK_DIV(TICK_DIV),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    int h;
    int arm_len;
    int extra;
    int exp_w;
    int exp_e;
    int exp_v;
  } vec_t;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle numbers count from the clock edge that first samples arm high.
  // d: edge at which echo is first sampled high (negative: already high before arm); h: high length.
  function automatic void model(input int d, input int h, output int w, output int e, output int v);
    int ticks;
    if ((d < 0) || (d + 1 > WAIT_MAX * TICK_DIV - 1)) begin
      w = 0;
      e = 1;
      v = WAIT_MAX * TICK_DIV + 1;
    end else begin
      ticks = h / TICK_DIV;
      if (ticks >= MAXV) begin
        w = MAXV;
        e = 1;
        v = d + 2 + MAXV * TICK_DIV + 1;
      end else begin
        w = ticks;
        e = 0;
        v = d + h + 3;
      end
    end
`ifdef ECHO_CM_EN
    if (e == 0) begin
      v = v + w / 58 + 1;
      w = w / 58;
    end
`endif
  endfunction

  function automatic logic echo_at(input int d, input int h, input int edge_n);
    if (d < 0) return (edge_n < h);
    return (edge_n >= d) && (edge_n < d + h);
  endfunction

  task automatic applyStimulus(input string name, input int d, input int h, input int arm_len,
                               input int extra, input int exp_w, input int exp_e, input int exp_v);
    int nvalid = 0;
    int vcyc   = -1;
    int vw     = 0;
    int ve     = 0;
    int vready = 0;
    int span;
    int last;
    span = ((d < 0) ? 0 : d) + h;
    last = ((span > exp_v) ? span : exp_v) + 8;
    @(negedge clk);
    if (d < 0) begin
      bus.echo = 1'b1;
      repeat (5) @(negedge clk);
    end
    bus.arm  = 1'b1;
    bus.echo = echo_at(d, h, 0);
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      if (cyc == 1) checkOutput({name, " ready_busy"}, int'(bus.ready), 0);
      if (bus.valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc   = cyc;
          vw     = int'(bus.width);
          ve     = int'(bus.timeout_err);
          vready = int'(bus.ready);
        end
      end
      bus.arm  = ((cyc + 1) < arm_len) || ((cyc + 1) == extra);
      bus.echo = echo_at(d, h, cyc + 1);
    end
    checkOutput({name, " valid_count"}, nvalid, 1);
    checkOutput({name, " valid_cycle"}, vcyc, exp_v);
    checkOutput({name, " width"}, vw, exp_w);
    checkOutput({name, " timeout_err"}, ve, exp_e);
    checkOutput({name, " ready_at_valid"}, vready, 1);
    checkOutput({name, " width_hold"}, int'(bus.width), exp_w);
    bus.arm  = 1'b0;
    bus.echo = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  vec_t vecs[11];

  initial begin
    int d, h, al, ex, w, e, v, nv;
    bus.arm  = 1'b0;
    bus.echo = 1'b0;

    // Expected values in ticks; the centimetre build rescales them below.
    vecs[0]  = '{8,    40,   1, 0,  10,  0, 51};
    vecs[1]  = '{1,    3,    1, 0,  0,   0, 7};
    vecs[2]  = '{1,    4,    1, 0,  1,   0, 8};
    vecs[3]  = '{38,   8,    1, 0,  2,   0, 49};
    vecs[4]  = '{39,   8,    1, 0,  0,   1, 41};
    vecs[5]  = '{60,   5,    1, 0,  0,   1, 41};
    vecs[6]  = '{-1,   60,   1, 0,  0,   1, 41};
    vecs[7]  = '{5,    1100, 1, 0,  255, 1, 1028};
    vecs[8]  = '{5,    1019, 1, 0,  254, 0, 1027};
    vecs[9]  = '{8,    40, 200, 0,  10,  0, 51};
    vecs[10] = '{8,    40,   3, 30, 10,  0, 51};

    repeat (3) @(negedge clk);
    checkOutput("reset ready", int'(bus.ready), 1);
    checkOutput("reset valid", int'(bus.valid), 0);
    checkOutput("reset width", int'(bus.width), 0);
    checkOutput("reset timeout_err", int'(bus.timeout_err), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      w = vecs[i].exp_w;
      e = vecs[i].exp_e;
      v = vecs[i].exp_v;
`ifdef ECHO_CM_EN
      if (e == 0) begin
        v = v + w / 58 + 1;
        w = w / 58;
      end
`endif
      applyStimulus($sformatf("vec%0d", i), vecs[i].d, vecs[i].h, vecs[i].arm_len,
                    vecs[i].extra, w, e, v);
    end

    // Asynchronous reset in the middle of a measurement, then echo stays high with no arm.
    @(negedge clk);
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm  = 1'b0;
    bus.echo = 1'b1;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst ready", int'(bus.ready), 1);
    checkOutput("midrst valid", int'(bus.valid), 0);
    checkOutput("midrst width", int'(bus.width), 0);
    checkOutput("midrst timeout_err", int'(bus.timeout_err), 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    checkOutput("midrst no_valid", nv, 0);
    checkOutput("midrst ready_idle", int'(bus.ready), 1);
    bus.echo = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      d  = int'($urandom_range(1, 45));
      h  = ((i % 6) == 5) ? int'($urandom_range(1000, 1100)) : int'($urandom_range(1, 300));
      al = int'($urandom_range(1, 60));
      model(d, h, w, e, v);
      ex = 0;
      if (($urandom_range(0, 1) == 1) && (al + 1 < v)) ex = int'($urandom_range(al + 1, v));
      applyStimulus($sformatf("rnd%0d", i), d, h, al, ex, w, e, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
